// File: rtl/rr_priority_arbiter.sv
// Eight-way grant controller: fixed (highest bit) or rotating-priority arbitration with
// registered one-hot/binary grant, owner-driven release and a hold-timeout reclaim.
module rr_priority_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_req,
    input  logic       i_done,
    input  logic       i_mode,
    output logic [7:0] o_gnt,
    output logic [2:0] o_gnt_id,
    output logic       o_gnt_valid,
    output logic       o_timeout
);

    localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HoldLast = CW'(MAX_HOLD - 1);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e        r_state;
    logic [2:0]    r_ptr;
    logic [CW-1:0] r_cnt;

    logic [2:0] w_fix_id;
    logic [2:0] w_rr_id;
    logic [2:0] w_idx;
    logic [2:0] w_win;

    always_comb begin
        w_fix_id = 3'd0;
        w_rr_id  = 3'd0;
        w_idx    = 3'd0;
        // Ascending scan: the last hit is the highest set bit.
        for (int i = 0; i < 8; i++) begin
            if (i_req[i]) w_fix_id = 3'(i);
        end
        // Descending offset scan: the last hit is the first requester at or after r_ptr.
        for (int i = 7; i >= 0; i--) begin
            w_idx = r_ptr + 3'(i);
            if (i_req[w_idx]) w_rr_id = w_idx;
        end
        w_win = i_mode ? w_rr_id : w_fix_id;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_ptr       <= 3'd0;
            r_cnt       <= '0;
            o_gnt       <= 8'h00;
            o_gnt_id    <= 3'd0;
            o_gnt_valid <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (|i_req) begin
                        o_gnt       <= 8'd1 << w_win;
                        o_gnt_id    <= w_win;
                        o_gnt_valid <= 1'b1;
                        r_cnt       <= '0;
                        if (i_mode) r_ptr <= w_win + 3'd1;
                        r_state     <= StGrant;
                    end
                end
                StGrant: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_done || !i_req[o_gnt_id] || (r_cnt == HoldLast)) begin
                        o_gnt       <= 8'h00;
                        o_gnt_id    <= 3'd0;
                        o_gnt_valid <= 1'b0;
                        r_state     <= StIdle;
                        // Only a pure expiry is reported; a normal release wins a tie.
                        o_timeout   <= !i_done && i_req[o_gnt_id];
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/rr_priority_arbiter.md
# rr_priority_arbiter

Grant controller that shares one downstream resource among eight requesters. It uses the team's priority-encode scheme (highest set bit wins) in fixed mode, and a rotating-priority search in round-robin mode. It issues a registered one-hot grant plus a binary grant index and holds the grant until the owner releases it. A hold-timeout forcibly reclaims the resource from a requester that never releases. It sits between the requester bank and the shared datapath, and its `gnt_id` drives the datapath's source-select mux.

## Interface
- `MAX_HOLD`, default 16: maximum number of cycles a grant may be held before forced release. Legal range is 2..256.
- `clk` input 1: rising-edge clock for all state.
- `rst` input 1: synchronous, active-high reset.
- `req` input 8: request lines; bit i is requester i, held high while requesting.
- `done` input 1: release strobe from the current owner; sampled only while a grant is active.
- `mode` input 1: 0 selects fixed priority (bit 7 highest), 1 selects round-robin.
- `gnt` output 8: one-hot grant; all zeros when nothing is granted.
- `gnt_id` output 3: binary index of the granted requester; 0 when `gnt_valid`=0.
- `gnt_valid` output 1: high while a grant is active (equals |`gnt`).
- `timeout` output 1: one-cycle pulse when a grant is reclaimed by the hold counter.

## Operation
- **Reset.** All outputs are registered and reset to 0: `gnt`=8'h00, `gnt_id`=0, `gnt_valid`=0, `timeout`=0.
  - Internal state resets to: state=IDLE, round-robin pointer `ptr`=0, hold counter=0.
- **FSM states.** The FSM has two states, IDLE and GRANT.
- **IDLE.**
  - If `req`==0, remain in IDLE with outputs 0.
  - Otherwise select a winner w, load `gnt`=1<<w, `gnt_id`=w, `gnt_valid`=1, counter=0, and go to GRANT.
- **Fixed mode (`mode`=0).** w is the highest set bit of `req`; the `req`=0 case never reaches selection.
- **Round-robin mode (`mode`=1).**
  - Search upward from `ptr` with wrap-around (ptr, ptr+1, …, 7, 0, …, ptr-1). w is the first set bit found.
  - On each grant, `ptr` is set to (w+1) mod 8, using a 3-bit natural wrap.
  - `ptr` updates only when a grant is issued, and is unchanged in fixed mode.
- **GRANT.** The counter increments every cycle. Each cycle, check the release conditions in this priority order:
  1. `done`=1 → release, normal.
  2. `req[gnt_id]`=0 (the owner dropped its request) → release, normal.
  3. counter==MAX_HOLD-1 → release, forced; `timeout`=1 for the next cycle only.
  4. Otherwise hold all outputs.
- **Release.** Registered `gnt`, `gnt_id` and `gnt_valid` go to 0, and state returns to IDLE.
- **Simultaneous `done` and expiry.** `done` wins and no `timeout` pulse is generated.
- **Mode changes.** `mode` is sampled only in IDLE. Changing it during GRANT affects only the next arbitration.
- **Counter width.** The counter is clog2(MAX_HOLD) bits and never wraps, because it is cleared at every grant.
- **Other requesters.** Requests from non-owners during GRANT are ignored; no preemption.

## Timing
- **Grant latency.** `req` is sampled high at edge k while in IDLE, and `gnt` is visible after edge k, i.e. a one-cycle request-to-grant latency.
- **Release latency.**
  - `done` sampled at edge k: `gnt`=0 after edge k.
  - Minimum grant length is 1 cycle (`done` asserted in the first GRANT cycle).
- **Inter-grant gap.** Every release is followed by at least one IDLE cycle with `gnt`=0. Back-to-back grants are therefore separated by exactly one gap cycle, which guarantees the datapath mux a dead cycle.
- **Timeout timing.**
  - A non-releasing owner holds `gnt` for exactly MAX_HOLD cycles.
  - `timeout` is high during the first gap cycle, coincident with `gnt`=0.
- **Reset mid-operation.** `rst` sampled at any edge forces all outputs to 0 after that edge, regardless of state. The pending grant is abandoned and `ptr` returns to 0.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with `req`=8'hFF → `gnt`=0, `gnt_valid`=0, `timeout`=0 throughout; the first grant arrives 1 cycle after `rst` deasserts.
- **Fixed priority.** `mode`=0, `req`=8'b0010_0100 → after 1 cycle, `gnt`=8'b0010_0000, `gnt_id`=5. Pulse `done` → one gap cycle, then `gnt`=8'b0010_0000 again because bit 5 still wins.
- **Round-robin rotation.** `mode`=1, `req`=8'hFF held, `done` pulsed 2 cycles after each grant → `gnt_id` sequence 0,1,2,…,7,0 with one zero-`gnt` cycle between grants.
- **Round-robin skip and wrap.** `mode`=1, `ptr`=6 (after granting 5), `req`=8'b0000_0110 → `gnt_id`=1, then `ptr`=2.
- **Timeout.** `MAX_HOLD`=16, `req`=8'h08 held, no `done` → `gnt`=8'h08 for exactly 16 cycles, then `gnt`=0 with `timeout`=1 for 1 cycle. Re-grant to id 3 on the following edge.
- **Corner cases.**
  - Drop `req[gnt_id]` mid-grant → release on the next edge with no `timeout`.
  - `done` and expiry in the same cycle → no `timeout`.
  - `rst` during GRANT → `gnt`=0 after that edge and `ptr`=0.
